controlador_int: RTL and testbench

Interrupt controller sitting between the platform's peripheral request lines and the CPU's `interrupt` input. It is the source end of the CPU interrupt path: it captures and masks requests, prioritises them, and raises `irq` with a vector. It holds the request until the CPU acknowledges, then stays in service until end-of-interrupt. Its configuration registers sit on the CPU data/address bus as a memory-mapped responder.

---
 rtl/controlador_int.sv | 168 ++++++++++++++++
 tb/tb_controlador_int.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_int.sv
// rtl/controlador_int.sv - Interrupt controller: sync, pending/mask, fixed priority, irq/ack/eoi handshake.
// Optional CONTROLADOR_INT_EDGE_EN selects rising-edge request detection (default: level-sensitive).
module controlador_int #(
    parameter int               N_IRQ    = 4,
    parameter int               VEC_W    = 10,
    parameter logic [VEC_W-1:0] VEC_BASE = 10'h3C0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata,
    output logic             irq,
    output logic [VEC_W-1:0] vector,
    input  logic             ack,
    input  logic             eoi,
    output logic             in_service
);

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_FORCE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   sync1, sync2, detect;
    logic [N_IRQ-1:0]   mask, pending, pending_d;
    logic [N_IRQ-1:0]   eligible, set_bits, clr_bits, ack_clr;
    logic [2:0]         idx_q, idx_d, win_idx;
    logic [VEC_W-1:0]   vector_d;
    logic               latched_elig, take_ack;
    logic               wr_mask, wr_clr, wr_force;
    logic               unused_wdata;

    assign unused_wdata = ^wdata[15:N_IRQ];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

`ifdef CONTROLADOR_INT_EDGE_EN
    logic [N_IRQ-1:0] sync3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync3 <= '0;
        else        sync3 <= sync2;
    end

    // Only a fresh 0->1 transition re-arms the request after it was acknowledged.
    assign detect = sync2 & ~sync3;
`else
    assign detect = sync2;
`endif

    assign wr_mask  = sel && we && (addr == REG_MASK);
    assign wr_clr   = sel && we && (addr == REG_PENDING);
    assign wr_force = sel && we && (addr == REG_FORCE);
    assign eligible = pending & mask;

    // Lowest index has the highest priority.
    always_comb begin
        win_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        latched_elig = 1'b0;
        ack_clr      = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (idx_q == 3'(i)) begin
                latched_elig = eligible[i];
                ack_clr[i]   = take_ack;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vector_d = vector;
        take_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|eligible) begin
                    idx_d    = win_idx;
                    vector_d = VEC_BASE + VEC_W'({win_idx, 2'b00});
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                // Request withdrawn by software before the CPU took it: abandon it.
                if (!latched_elig) begin
                    state_d = S_IDLE;
                end else if (ack) begin
                    take_ack = 1'b1;
                    state_d  = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (eoi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Set beats clear when both hit the same pending bit in one cycle.
    always_comb begin
        set_bits  = detect | (wr_force ? wdata[N_IRQ-1:0] : '0);
        clr_bits  = ack_clr | (wr_clr ? wdata[N_IRQ-1:0] : '0);
        pending_d = (pending & ~clr_bits) | set_bits;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask    <= '0;
            pending <= '0;
        end else begin
            pending <= pending_d;
            if (wr_mask) mask <= wdata[N_IRQ-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            vector     <= VEC_BASE;
            irq        <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vector     <= vector_d;
            irq        <= (state_d == S_REQ);
            in_service <= (state_d == S_SERVICE);
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                REG_MASK:    rdata = 16'(mask);
                REG_PENDING: rdata = 16'(pending);
                REG_STATUS:  rdata = {in_service, irq, 11'b0, idx_q};
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_int.sv
// tb/tb_controlador_int.sv - Scoreboarded bench for controlador_int (directed plan plus randomized model run).
module tb_controlador_int;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq;
    logic [9:0]  vector;
    logic        ack;
    logic        eoi;
    logic        in_service;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  exp_q[$];
    logic        irq_prev = 1'b0;
    logic [3:0]  pend_m;
    logic [3:0]  mask_m;

    controlador_int dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .irq        (irq),
        .vector     (vector),
        .ack        (ack),
        .eoi        (eoi),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising irq must match the oldest expected vector.
    always @(negedge clk) begin
        if (!reset) begin
            irq_prev = 1'b0;
        end else begin
            if (irq && !irq_prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_irq: got vector %0h expected no interrupt", vector);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if (vector !== e) begin
                        n_fail++;
                        $display("FAIL irq_vector: got %0h expected %0h", vector, e);
                    end
                end
            end
            irq_prev = irq;
        end
    end

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [9:0] vec_of(input int idx);
        return 10'(32'h3C0 + 4 * idx);
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [15:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(name, 32'(rdata), 32'(exp));
        sel = 1'b0;
    endtask

    task automatic pulse_ack;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic pulse_eoi;
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        for (int i = 0; i < 20 && !irq; i++) @(negedge clk);
        chk(name, 32'(irq), 32'd1);
    endtask

    initial begin
        reset = 1'b0; irq_in = '0; sel = 1'b0; we = 1'b0; addr = '0;
        wdata = '0; ack = 1'b0; eoi = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_vector", 32'(vector), 32'h3C0);
        chk("rst_rdata_nosel", 32'(rdata), 0);
        reset = 1'b1;
        @(negedge clk);
        chk_reg("rst_mask", 2'd0, 16'h0);
        chk_reg("rst_pending", 2'd1, 16'h0);
        chk_reg("rst_status", 2'd2, 16'h0);

        // Two simultaneous lines: lowest index first, then the other.
        bus_write(2'd0, 16'hF);
        irq_in = 4'b0101;
        exp_q.push_back(10'h3C0);
        repeat (3) @(negedge clk);
        chk("sim_irq_early", 32'(irq), 0);
        chk_reg("sim_pending", 2'd1, 16'h5);
        @(negedge clk);
        chk("sim_irq_rise", 32'(irq), 1);
        irq_in = '0;
        repeat (3) @(negedge clk);
        pulse_ack;
        chk("sim_ack_is", 32'(in_service), 1);
        chk("sim_ack_irq", 32'(irq), 0);
        chk_reg("sim_ack_pending", 2'd1, 16'h4);
        exp_q.push_back(10'h3C8);
        pulse_eoi;
        chk("sim_eoi_is", 32'(in_service), 0);
        chk("sim_eoi_gap", 32'(irq), 0);
        @(negedge clk);
        chk("sim_second_irq", 32'(irq), 1);
        pulse_ack;
        pulse_eoi;

        // No preemption by a higher-priority arrival.
        exp_q.push_back(10'h3CC);
        bus_write(2'd3, 16'h8);
        wait_irq("np_irq");
        irq_in = 4'b0001;
        repeat (5) @(negedge clk);
        chk("np_vector_frozen", 32'(vector), 32'h3CC);
        chk("np_irq_held", 32'(irq), 1);
        irq_in = '0;
        repeat (3) @(negedge clk);
        pulse_ack;
        chk("np_vector_service", 32'(vector), 32'h3CC);
        chk_reg("np_pending", 2'd1, 16'h1);
        exp_q.push_back(10'h3C0);
        pulse_eoi;
        wait_irq("np_irq2");
        pulse_ack;
        pulse_eoi;

        // Masking, including withdrawal while requesting.
        bus_write(2'd0, 16'h0);
        bus_write(2'd3, 16'h2);
        repeat (3) @(negedge clk);
        chk("mk_irq_masked", 32'(irq), 0);
        chk_reg("mk_pending", 2'd1, 16'h2);
        exp_q.push_back(10'h3C4);
        bus_write(2'd0, 16'h2);
        chk("mk_irq_wait", 32'(irq), 0);
        @(negedge clk);
        chk("mk_irq_rise", 32'(irq), 1);
        chk_reg("mk_status_req", 2'd2, 16'h4001);
        bus_write(2'd0, 16'h0);
        @(negedge clk);
        chk("mk_irq_drop", 32'(irq), 0);
        chk("mk_is_drop", 32'(in_service), 0);
        chk_reg("mk_pending_kept", 2'd1, 16'h2);

        // W1C racing a detection on the same bit: set wins.
        irq_in = 4'b0010;
        repeat (2) @(negedge clk);
        bus_write(2'd1, 16'h2);
        chk_reg("w1c_vs_set", 2'd1, 16'h2);
        irq_in = '0;
        repeat (4) @(negedge clk);
        bus_write(2'd1, 16'h2);
        chk_reg("w1c_clear", 2'd1, 16'h0);

        // ack clear racing FORCE on the same bit, then spurious ack/eoi.
        bus_write(2'd3, 16'h2);
        exp_q.push_back(10'h3C4);
        bus_write(2'd0, 16'h2);
        wait_irq("af_irq");
        ack = 1'b1; sel = 1'b1; we = 1'b1; addr = 2'd3; wdata = 16'h2;
        @(negedge clk);
        ack = 1'b0; sel = 1'b0; we = 1'b0; wdata = '0;
        chk("af_is", 32'(in_service), 1);
        chk_reg("af_pending", 2'd1, 16'h2);
        pulse_ack;
        chk("spur_ack_is", 32'(in_service), 1);
        chk("spur_ack_irq", 32'(irq), 0);
        chk_reg("spur_ack_pending", 2'd1, 16'h2);
        exp_q.push_back(10'h3C4);
        pulse_eoi;
        wait_irq("af_irq2");
        pulse_ack;
        pulse_eoi;
        pulse_eoi;
        chk("spur_eoi_irq", 32'(irq), 0);
        chk("spur_eoi_is", 32'(in_service), 0);
        chk_reg("spur_eoi_pending", 2'd1, 16'h0);

        // Held-high line through a full ack/eoi.
        bus_write(2'd0, 16'h1);
        irq_in = 4'b0001;
        exp_q.push_back(10'h3C0);
        wait_irq("hh_irq");
        pulse_ack;
        repeat (3) @(negedge clk);
`ifdef CONTROLADOR_INT_EDGE_EN
        chk_reg("hh_pending_edge", 2'd1, 16'h0);
        pulse_eoi;
        repeat (10) @(negedge clk);
        chk("hh_single_irq", 32'(irq), 0);
        irq_in = '0;
`else
        chk_reg("hh_pending_level", 2'd1, 16'h1);
        exp_q.push_back(10'h3C0);
        pulse_eoi;
        chk("hh_gap", 32'(irq), 0);
        @(negedge clk);
        chk("hh_reassert", 32'(irq), 1);
        irq_in = '0;
        repeat (3) @(negedge clk);
        pulse_ack;
        repeat (2) @(negedge clk);
        pulse_eoi;
        chk_reg("hh_pending_done", 2'd1, 16'h0);
`endif
        bus_write(2'd0, 16'h0);

        // Randomized: software-forced batches served in priority order.
        pend_m = '0;
        for (int it = 0; it < 30; it++) begin
            logic [3:0] c, f, m;
            int         w;
            bus_write(2'd0, 16'h0);
            c = 4'($urandom);
            bus_write(2'd1, 16'(c));
            pend_m = pend_m & ~c;
            f = 4'($urandom);
            bus_write(2'd3, 16'(f));
            pend_m = pend_m | f;
            chk_reg("rnd_pending", 2'd1, 16'(pend_m));
            m = 4'($urandom);
            mask_m = m;
            w = lowest(pend_m & mask_m);
            if (w >= 0) exp_q.push_back(vec_of(w));
            bus_write(2'd0, 16'(m));
            if (w < 0) begin
                repeat (3) @(negedge clk);
                chk("rnd_no_irq", 32'(irq), 0);
            end
            while (w >= 0) begin
                wait_irq("rnd_irq");
                chk_reg("rnd_status", 2'd2, 16'h4000 | 16'(w));
                pulse_ack;
                pend_m[w] = 1'b0;
                chk("rnd_is", 32'(in_service), 1);
                chk_reg("rnd_pending_ack", 2'd1, 16'(pend_m));
                w = lowest(pend_m & mask_m);
                if (w >= 0) exp_q.push_back(vec_of(w));
                pulse_eoi;
            end
        end
        bus_write(2'd0, 16'h0);

        // Asynchronous reset while requesting.
        bus_write(2'd0, 16'h2);
        irq_in = 4'b0010;
        exp_q.push_back(10'h3C4);
        wait_irq("rr_irq");
        #2;
        reset = 1'b0;
        #1;
        chk("rr_irq", 32'(irq), 0);
        chk("rr_is", 32'(in_service), 0);
        chk("rr_vector", 32'(vector), 32'h3C0);
        sel = 1'b1; addr = 2'd1;
        #1;
        chk("rr_pending", 32'(rdata), 0);
        addr = 2'd0;
        #1;
        chk("rr_mask", 32'(rdata), 0);
        sel = 1'b0;
        irq_in = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rr_quiet", 32'(irq), 0);

        chk("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
